// File: rtl/line_scan_sequencer.sv
// Line-sensor scan sequencer: shares one ADC across the left/centre/right
// sensors, thresholds each sample with hysteresis, publishes a {L,C,R} line
// pattern once per frame and confirms node (110 / 011) detections.
module line_scan_sequencer #(
   parameter int unsigned ADC_W         = 10,
   parameter int unsigned THRESH_LO     = 400,
   parameter int unsigned THRESH_HI     = 600,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned TIMEOUT       = 64,
   parameter int unsigned NODE_CONFIRM  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   output logic [1:0]       adc_ch_o,
   output logic             adc_start_o,
   input  logic             adc_done_i,
   input  logic [ADC_W-1:0] adc_data_i,
   output logic [2:0]       line_o,
   output logic             line_valid_o,
   output logic             node_left_o,
   output logic             node_right_o,
   output logic             adc_err_o,
   input  logic             err_clr_i
);

   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned CW = $clog2(NODE_CONFIRM + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_START, S_WAIT, S_LATCH, S_PUBLISH
   } state_t;

   typedef enum logic [1:0] {
      CAND_NONE, CAND_L, CAND_R
   } cand_t;

   state_t           state_q;
   logic [1:0]       ch_q;
   logic [SW-1:0]    settle_q;
   logic [TW-1:0]    tmo_q;
   logic [ADC_W-1:0] sample_q;
   logic             sample_ok_q;   // 0 when the conversion timed out
   logic [2:0]       work_q;        // shadow line bits, published at frame end
   logic [2:0]       line_q;
   logic             line_valid_q;
   logic             start_q;
   logic             node_l_q;
   logic             node_r_q;
   logic             err_q;
   cand_t            cand_q;
   logic [CW-1:0]    cnt_q;

   logic [2:0]       work_d;
   logic [1:0]       idx_d;
   cand_t            cand_d;
   logic [CW-1:0]    cnt_d;
   logic             fire_d;

   // Hysteresis: set below THRESH_LO, clear at/above THRESH_HI, else hold.
   function automatic logic hyst(input logic cur, input logic [ADC_W-1:0] s);
      logic r;
      r = cur;
      if (!cur && (32'(s) < 32'(THRESH_LO)))
         r = 1'b1;
      else if (cur && (32'(s) >= 32'(THRESH_HI)))
         r = 1'b0;
      return r;
   endfunction

   // Next working bits for the channel in LATCH, and node tracking on the resulting pattern.
   always_comb begin
      work_d = work_q;
      idx_d  = 2'd2 - ch_q;             // ch0 is L = bit 2
      if (sample_ok_q)
         work_d[idx_d] = hyst(work_q[idx_d], sample_q);

      cand_d = CAND_NONE;
      if (work_d == 3'b110)
         cand_d = CAND_L;
      else if (work_d == 3'b011)
         cand_d = CAND_R;

      cnt_d  = '0;
      fire_d = 1'b0;
      if (cand_d != CAND_NONE) begin
         if (cand_d != cand_q)
            cnt_d = CW'(1);
         else if (cnt_q == CW'(NODE_CONFIRM))
            cnt_d = cnt_q;
         else
            cnt_d = cnt_q + 1'b1;
         // Pulse only on the frame that first reaches the confirm count.
         fire_d = (cnt_d == CW'(NODE_CONFIRM)) &&
                  ((cand_d != cand_q) || (cnt_q != CW'(NODE_CONFIRM)));
      end
   end

   // Scan FSM with registered outputs; line/node outputs are loaded on entry to PUBLISH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ch_q         <= 2'd0;
         settle_q     <= '0;
         tmo_q        <= '0;
         sample_q     <= '0;
         sample_ok_q  <= 1'b0;
         work_q       <= 3'b000;
         line_q       <= 3'b000;
         line_valid_q <= 1'b0;
         start_q      <= 1'b0;
         node_l_q     <= 1'b0;
         node_r_q     <= 1'b0;
         err_q        <= 1'b0;
         cand_q       <= CAND_NONE;
         cnt_q        <= '0;
      end else begin
         start_q      <= 1'b0;
         line_valid_q <= 1'b0;
         node_l_q     <= 1'b0;
         node_r_q     <= 1'b0;
         // A timeout set below overrides this clear.
         if (err_clr_i)
            err_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               ch_q <= 2'd0;
               if (enable_i) begin
                  settle_q <= '0;
                  state_q  <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                  start_q <= 1'b1;
                  state_q <= S_START;
               end else begin
                  settle_q <= settle_q + 1'b1;
               end
            end
            S_START: begin
               tmo_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (adc_done_i) begin
                  sample_q    <= adc_data_i;
                  sample_ok_q <= 1'b1;
                  state_q     <= S_LATCH;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  sample_ok_q <= 1'b0;
                  err_q       <= 1'b1;
                  state_q     <= S_LATCH;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            S_LATCH: begin
               work_q <= work_d;
               if (ch_q < 2'd2) begin
                  ch_q     <= ch_q + 2'd1;
                  settle_q <= '0;
                  state_q  <= S_SELECT;
               end else begin
                  line_q       <= work_d;
                  line_valid_q <= 1'b1;
                  cand_q       <= cand_d;
                  cnt_q        <= cnt_d;
                  node_l_q     <= fire_d && (cand_d == CAND_L);
                  node_r_q     <= fire_d && (cand_d == CAND_R);
                  state_q      <= S_PUBLISH;
               end
            end
            S_PUBLISH: begin
               ch_q <= 2'd0;
               if (enable_i) begin
                  settle_q <= '0;
                  state_q  <= S_SELECT;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign adc_ch_o     = ch_q;
   assign adc_start_o  = start_q;
   assign line_o       = line_q;
   assign line_valid_o = line_valid_q;
   assign node_left_o  = node_l_q;
   assign node_right_o = node_r_q;
   assign adc_err_o    = err_q;

endmodule
